// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single SPI memory controller. A read-only
// fetch port and a read/write data port each raise a level request; the
// arbiter grants one of them, forwards the owner's request fields to the
// memory side, waits for the controller to finish, returns the read value
// and a done flag, then waits for the owner to drop its request before
// returning to IDLE.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   f_req/f_addr/f_num_bytes, f_done
//                     : fetch port (read only)
//   d_req/d_addr/d_num_bytes/d_is_write/d_wdata, d_done
//                     : data port
//   rdata             : registered read value of the last completed transfer
//   mem_start/mem_addr/mem_num_bytes/mem_is_write/mem_wdata
//                     : request towards the SPI memory controller
//   mem_done/mem_rdata: controller's request_done / fetched_value
//   busy              : high whenever the arbiter is not in IDLE
//
// Configuration
//   MEM_ARBITER_RR_EN : when defined, simultaneous requests are granted
//                       round-robin (the port that did not own the previous
//                       transfer wins). When undefined, the data port always
//                       wins a simultaneous request.
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        f_req,
  input  logic [24:0] f_addr,
  input  logic [2:0]  f_num_bytes,
  output logic        f_done,
  // data port
  input  logic        d_req,
  input  logic [24:0] d_addr,
  input  logic [2:0]  d_num_bytes,
  input  logic        d_is_write,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  // shared read value
  output logic [31:0] rdata,
  // memory side
  output logic        mem_start,
  output logic [24:0] mem_addr,
  output logic [2:0]  mem_num_bytes,
  output logic        mem_is_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        mem_start_q, mem_start_d;
  logic        f_done_q, f_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        grant_data;
  logic        owner_req;

`ifdef MEM_ARBITER_RR_EN
  // Owner of the most recent grant; reset to data so fetch wins the first tie.
  logic        last_q, last_d;
`endif

  // Arbitration decision, only consumed while in IDLE.
  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    if (f_req && d_req) begin
      grant_data = (last_q == OWN_F);
    end else begin
      grant_data = d_req;
    end
`else
    grant_data = d_req;
`endif
  end

  assign owner_req = (owner_q == OWN_D) ? d_req : f_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_start_d = mem_start_q;
    f_done_d    = f_done_q;
    d_done_d    = d_done_q;
    rdata_d     = rdata_q;
`ifdef MEM_ARBITER_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          owner_d     = grant_data ? OWN_D : OWN_F;
          mem_start_d = 1'b1;
          state_d     = BUSY;
`ifdef MEM_ARBITER_RR_EN
          last_d      = grant_data ? OWN_D : OWN_F;
`endif
        end
      end
      BUSY: begin
        // The transfer completes even if the owner has already dropped req.
        if (mem_done) begin
          rdata_d     = mem_rdata;
          mem_start_d = 1'b0;
          state_d     = RELEASE;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
          end else begin
            f_done_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        // Waiting for mem_done to fall as well keeps a stretched done pulse
        // from the controller from being mistaken for a new completion.
        if (!owner_req && !mem_done) begin
          f_done_d = 1'b0;
          d_done_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_start_d = 1'b0;
        f_done_d    = 1'b0;
        d_done_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      mem_start_q <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      rdata_q     <= 32'd0;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= OWN_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_start_q <= mem_start_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ARBITER_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Memory-side request fields follow the owner's live inputs; zero in IDLE.
  always_comb begin
    mem_addr      = 25'd0;
    mem_num_bytes = 3'd0;
    mem_is_write  = 1'b0;
    mem_wdata     = 32'd0;
    if (state_q != IDLE) begin
      if (owner_q == OWN_D) begin
        mem_addr      = d_addr;
        mem_num_bytes = d_num_bytes;
        mem_is_write  = d_is_write;
        mem_wdata     = d_wdata;
      end else begin
        mem_addr      = f_addr;
        mem_num_bytes = f_num_bytes;
      end
    end
  end

  assign mem_start = mem_start_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A behavioural model tracks "is a port granted, has
// its transfer completed, who owns it" and a compare process checks every
// DUT output against it on each falling clock edge. A small memory model
// answers mem_start after a (fixed or random) latency. Directed scenarios
// carry literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        f_req = 1'b0;
  logic [24:0] f_addr = '0;
  logic [2:0]  f_num_bytes = '0;
  logic        f_done;
  logic        d_req = 1'b0;
  logic [24:0] d_addr = '0;
  logic [2:0]  d_num_bytes = '0;
  logic        d_is_write = 1'b0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] rdata;
  logic        mem_start;
  logic [24:0] mem_addr;
  logic [2:0]  mem_num_bytes;
  logic        mem_is_write;
  logic [31:0] mem_wdata;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_num_bytes(f_num_bytes), .f_done(f_done),
    .d_req(d_req), .d_addr(d_addr), .d_num_bytes(d_num_bytes),
    .d_is_write(d_is_write), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_num_bytes(mem_num_bytes),
    .mem_is_write(mem_is_write), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (port 0 = fetch, 1 = data) ----------
  bit          m_granted;
  bit          m_completed;
  bit          m_owner;
  bit          m_last;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_granted   = 0;
    m_completed = 0;
    m_owner     = 0;
    m_last      = 1;
    m_rdata     = 32'd0;
  endtask

  task automatic model_step();
    bit w;
    if (!m_granted) begin
      if (f_req || d_req) begin
`ifdef MEM_ARBITER_RR_EN
        if (f_req && d_req) w = !m_last;
        else                w = d_req;
`else
        w = d_req;
`endif
        m_owner     = w;
        m_last      = w;
        m_granted   = 1;
        m_completed = 0;
      end
    end else if (!m_completed) begin
      if (mem_done) begin
        m_completed = 1;
        m_rdata     = mem_rdata;
      end
    end else begin
      if (!(m_owner ? d_req : f_req) && !mem_done) m_granted = 0;
    end
  endtask

  // ---------------- memory model --------------------------------------------
  bit          mem_active = 0;
  int          lat = 0;
  int          hold_left = 0;
  int          force_lat = 0;
  bit          force_rd_en = 0;
  logic [31:0] force_rdata = '0;

  task automatic mem_reset();
    mem_done   = 1'b0;
    mem_active = 0;
    lat        = 0;
    hold_left  = 0;
  endtask

  task automatic mem_drive();
    if (mem_done) begin
      hold_left--;
      if (hold_left <= 0) begin
        mem_done   = 1'b0;
        mem_active = 0;
      end
    end else if (mem_active) begin
      lat--;
      if (lat <= 0) begin
        mem_done  = 1'b1;
        mem_rdata = force_rd_en ? force_rdata : $urandom;
        hold_left = (force_lat != 0) ? 1 : int'($urandom_range(1, 2));
      end
    end else if (mem_start) begin
      mem_active = 1;
      lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
    end
  endtask

  // ---------------- random requesters ---------------------------------------
  bit rand_en = 0;

  task automatic req_drive();
    logic [31:0] r;
    if (!f_req) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        f_addr      = r[24:0];
        f_num_bytes = r[31:29];
        f_req       = 1'b1;
      end
    end else if (f_done) begin
      if ($urandom_range(0, 1) == 0) f_req = 1'b0;
    end else if (m_granted && !m_owner && !m_completed && $urandom_range(0, 15) == 0) begin
      f_req = 1'b0;
    end
    if (!d_req) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom;
        d_addr      = r[24:0];
        d_num_bytes = r[31:29];
        d_is_write  = r[28];
        d_wdata     = $urandom;
        d_req       = 1'b1;
      end
    end else if (d_done) begin
      if ($urandom_range(0, 1) == 0) d_req = 1'b0;
    end else if (m_granted && m_owner && !m_completed && $urandom_range(0, 15) == 0) begin
      d_req = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    mem_drive();
    if (rand_en) req_drive();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      cycle();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // ---------------- compare process -----------------------------------------
  bit          chk_en = 0;
  logic [24:0] e_addr;
  logic [2:0]  e_nb;
  logic        e_wr;
  logic [31:0] e_wdata;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      e_addr  = '0;
      e_nb    = '0;
      e_wr    = 1'b0;
      e_wdata = '0;
      if (m_granted) begin
        e_addr  = m_owner ? d_addr : f_addr;
        e_nb    = m_owner ? d_num_bytes : f_num_bytes;
        e_wr    = m_owner & d_is_write;
        e_wdata = m_owner ? d_wdata : 32'd0;
      end
      check("busy",          32'(busy),          32'(m_granted));
      check("mem_start",     32'(mem_start),     32'(m_granted && !m_completed));
      check("f_done",        32'(f_done),        32'(m_granted && m_completed && !m_owner));
      check("d_done",        32'(d_done),        32'(m_granted && m_completed && m_owner));
      check("rdata",         rdata,              m_rdata);
      check("mem_addr",      32'(mem_addr),      32'(e_addr));
      check("mem_num_bytes", 32'(mem_num_bytes), 32'(e_nb));
      check("mem_is_write",  32'(mem_is_write),  32'(e_wr));
      check("mem_wdata",     mem_wdata,          e_wdata);
      check("done_excl",     32'(f_done & d_done), 32'd0);
    end
  end

  // ---------------- stimulus ------------------------------------------------
  int n;
  int ndone;
  bit first_d;
  bit loser_seen;
  bit exp_rr [3];

  initial begin
    model_reset();
    mem_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mem_start", 32'(mem_start), 32'd0);
    check("rst_f_done",    32'(f_done),    32'd0);
    check("rst_d_done",    32'(d_done),    32'd0);
    check("rst_rdata",     rdata,          32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;

    // Single fetch, memory answers 3 cycles after mem_start.
    force_lat = 3; force_rd_en = 1; force_rdata = 32'h00A00513;
    f_addr = 25'h000010; f_num_bytes = 3'd4; f_req = 1'b1;
    cycle();
    check("fetch_start",    32'(mem_start),    32'd1);
    check("fetch_is_write", 32'(mem_is_write), 32'd0);
    check("fetch_addr",     32'(mem_addr),     32'h10);
    n = 0;
    while (!f_done && n < 20) begin cycle(); n++; end
    check("fetch_done_latency", 32'(n), 32'd4);
    check("fetch_rdata",        rdata,  32'h00A00513);
    f_req = 1'b0;
    cycle();
    check("fetch_idle", 32'(busy), 32'd0);

    // Data store.
    force_lat = 2; force_rd_en = 0;
    d_addr = 25'h1000004; d_wdata = 32'hDEADBEEF; d_num_bytes = 3'd4;
    d_is_write = 1'b1; d_req = 1'b1;
    cycle();
    check("store_addr",     32'(mem_addr),      32'h1000004);
    check("store_wdata",    mem_wdata,          32'hDEADBEEF);
    check("store_is_write", 32'(mem_is_write),  32'd1);
    check("store_nb",       32'(mem_num_bytes), 32'd4);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (d_done) begin ndone++; d_req = 1'b0; end
    end
    check("store_done_count", 32'(ndone), 32'd1);
    d_is_write = 1'b0;
    wait_idle("store_idle");

    // Contention: both rise together. Last owner was data, so round-robin
    // hands the tie to fetch; fixed priority hands it to data.
`ifdef MEM_ARBITER_RR_EN
    first_d = 0;
`else
    first_d = 1;
`endif
    f_addr = 25'h100; d_addr = 25'h200;
    f_req = 1'b1; d_req = 1'b1;
    cycle();
    check("cont_first_addr", 32'(mem_addr), first_d ? 32'h200 : 32'h100);
    n = 0; loser_seen = 0;
    while (!(first_d ? d_done : f_done) && n < 20) begin
      if (first_d ? f_done : d_done) loser_seen = 1;
      cycle(); n++;
    end
    check("cont_first_done", 32'(first_d ? d_done : f_done), 32'd1);
    check("cont_loser_quiet", 32'(loser_seen), 32'd0);
    if (first_d) d_req = 1'b0; else f_req = 1'b0;
    cycle();
    check("cont_gap_idle", 32'(busy), 32'd0);
    cycle();
    check("cont_second_start", 32'(mem_start), 32'd1);
    check("cont_second_addr",  32'(mem_addr),  first_d ? 32'h100 : 32'h200);
    n = 0;
    while (!(first_d ? f_done : d_done) && n < 20) begin cycle(); n++; end
    check("cont_second_done", 32'(first_d ? f_done : d_done), 32'd1);
    f_req = 1'b0; d_req = 1'b0;
    wait_idle("cont_idle");

    // Three back-to-back simultaneous pairs.
`ifdef MEM_ARBITER_RR_EN
    exp_rr = '{1'b0, 1'b1, 1'b0};
`else
    exp_rr = '{1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 3; k++) begin
      f_req = 1'b1; d_req = 1'b1;
      cycle();
      check("pair_dut_owner",   32'(mem_addr == 25'h200), 32'(exp_rr[k]));
      check("pair_model_owner", 32'(m_owner),             32'(exp_rr[k]));
      n = 0;
      while (!(f_done || d_done) && n < 20) begin cycle(); n++; end
      check("pair_done", 32'(f_done | d_done), 32'd1);
      f_req = 1'b0; d_req = 1'b0;
      wait_idle("pair_idle");
      cycle();
    end

    // Owner drops d_req while BUSY: transfer still completes, 1-cycle done.
    force_lat = 3;
    d_addr = 25'h0ABCDE; d_req = 1'b1;
    cycle();
    cycle();
    d_req = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (d_done) ndone++;
    end
    check("drop_done_count", 32'(ndone), 32'd1);
    check("drop_idle",       32'(busy),  32'd0);

    // Randomized traffic.
    force_lat = 0;
    rand_en = 1;
    for (int i = 0; i < 3000; i++) cycle();
    rand_en = 0;
    f_req = 1'b0; d_req = 1'b0;
    wait_idle("rand_idle");
    cycle();

    // Reset two cycles into BUSY.
    force_lat = 6;
    f_addr = 25'h40; f_req = 1'b1;
    cycle();
    cycle();
    cycle();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_start", 32'(mem_start), 32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_f_done",    32'(f_done),    32'd0);
    check("arst_d_done",    32'(d_done),    32'd0);
    f_req = 1'b0;
    model_reset();
    mem_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (f_done || d_done || busy) ndone++;
    end
    check("post_rst_quiet", 32'(ndone), 32'd0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have fetch port inputs: f_req (1, level request), f_addr (25, byte address), f_num_bytes (3). Fetch port is read-only.
REQ-004 SHALL have fetch port output f_done (1, transfer complete, held until f_req drops).
REQ-005 SHALL have data port inputs: d_req (1), d_addr (25), d_num_bytes (3), d_is_write (1), d_wdata (32).
REQ-006 SHALL have data port output d_done (1, transfer complete, held until d_req drops).
REQ-007 SHALL have output rdata (32), the registered read value of the last completed transfer, shared by both ports.
REQ-008 SHALL have memory-side outputs: mem_start (1), mem_addr (25), mem_num_bytes (3), mem_is_write (1), mem_wdata (32).
REQ-009 SHALL have memory-side inputs: mem_done (1) and mem_rdata (32), wired to the SPI memory controller's request_done and fetched_value.
REQ-010 SHALL have output busy (1), high in every state except IDLE.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, BUSY, RELEASE.
REQ-012 In IDLE, when any request is high, the arbiter SHALL register owner, set mem_start<=1 and enter BUSY, so mem_start is high one cycle after the request is sampled.
REQ-013 Default priority SHALL be fixed: data port wins when f_req and d_req are both high in IDLE.
REQ-014 mem_addr, mem_num_bytes, mem_is_write and mem_wdata SHALL be driven combinationally from the registered owner's inputs.
REQ-015 mem_is_write SHALL be 0 whenever the owner is the fetch port; all mem_* outputs except mem_start SHALL be 0 in IDLE.
REQ-016 In BUSY with mem_done=1, the arbiter SHALL: capture rdata<=mem_rdata; set the owner's done<=1; clear mem_start<=0; enter RELEASE.
REQ-017 In RELEASE, when both the owner's req is 0 and mem_done is 0, the arbiter SHALL clear the owner's done and return to IDLE.
REQ-018 A new grant SHALL never occur before the IDLE return, giving a minimum 1 idle cycle between transfers.
REQ-019 If the owner drops req while in BUSY, the transfer SHALL still complete. done then pulses for exactly 1 cycle, because RELEASE exits as soon as mem_done falls.
REQ-020 The non-owner's req SHALL be ignored (its done held 0) until the FSM re-enters IDLE; it is never lost.
REQ-021 f_done and d_done SHALL never be high simultaneously.
REQ-022 Owner-side req/addr changes during BUSY SHALL be the requester's responsibility. Inputs SHALL be held stable by requesters; the arbiter does not latch them.

Reset
REQ-023 On rst_n=0, asynchronously: state=IDLE, mem_start=0, f_done=0, d_done=0, rdata=0, owner=fetch, busy=0.
REQ-024 Reset mid-transfer SHALL drop mem_start immediately. No done SHALL be issued for the aborted transfer after reset release.

Configuration
REQ-025 Macro MEM_ARBITER_RR_EN SHALL control the arbitration policy.
REQ-026 With MEM_ARBITER_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the port that was not the previous owner (round-robin). A last-owner flag is updated at each grant and reset to data, so fetch wins the first contention.
REQ-027 With MEM_ARBITER_RR_EN undefined, the fixed data-first priority of REQ-013 SHALL apply and the last-owner flag SHALL not exist.

Verification
REQ-028 Single fetch: f_req=1, f_addr=0x000010, f_num_bytes=4; memory model sets mem_done 3 cycles after mem_start with mem_rdata=0x00A00513 -> mem_start high 1 cycle after f_req; mem_is_write=0; f_done=1 and rdata=0x00A00513 on the cycle after mem_done; return to IDLE after f_req drops.
REQ-029 Data store: d_req=1, d_is_write=1, d_addr=0x1000004, d_wdata=0xDEADBEEF, d_num_bytes=4 -> mem_addr=0x1000004, mem_wdata=0xDEADBEEF, mem_is_write=1 throughout BUSY; d_done asserted once.
REQ-030 Contention, fixed priority: f_req and d_req rise in the same cycle -> data granted first; fetch granted in the cycle after the data transaction's RELEASE->IDLE; f_done stays 0 until then.
REQ-031 Contention with MEM_ARBITER_RR_EN: three back-to-back simultaneous request pairs -> grant order fetch, data, fetch.
REQ-032 Owner drops d_req in BUSY -> transfer completes; d_done high exactly 1 cycle.
REQ-033 rst_n pulled low 2 cycles into BUSY -> mem_start, busy and all done signals go 0 without a clock edge; after release, state is IDLE and no done appears.
